// File: rtl/iiitb_sysarr_stream.sv
// ---------------------------------------------------------------------------
// iiitb_sysarr_stream
//
// Streaming diagonal systolic dot-product array. Each accepted beat carries
// ODR operand pairs. Lane k passes through k skew registers before reaching
// PE k, so PE k adds lane k's product one cycle after PE k-1 has added its
// own. The partial sum therefore ripples down the chain together with the
// beat's valid/last bits. The tail of the chain feeds an accumulator that
// sums consecutive beats until a beat marked in_last closes the dot product.
// That closing sum is loaded into the output register.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a beat is offered on in_a/in_b/ker_len/in_last
//   in_ready   the beat is taken when in_valid & in_ready at a rising edge
//   in_a       lane k operand A = in_a[k*DW +: DW] (unsigned)
//   in_b       lane k operand B = in_b[k*DW +: DW] (unsigned)
//   ker_len    number of active lanes for this beat (values above ODR act as ODR)
//   in_last    this beat closes the current dot product
//   out_valid  out_data holds a result
//   out_ready  the result is consumed when out_valid & out_ready at a rising edge
//   out_data   accumulated dot product, modulo 2^ACCW
// ---------------------------------------------------------------------------
module iiitb_sysarr_stream #(
    parameter int DW   = 8,
    parameter int ODR  = 4,
    parameter int KLW  = $clog2(ODR + 1),
    parameter int ACCW = 2 * DW + $clog2(ODR)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ODR*DW-1:0]   in_a,
    input  logic [ODR*DW-1:0]   in_b,
    input  logic [KLW-1:0]      ker_len,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACCW-1:0]     out_data
);

    // A result that is held because the consumer is not ready freezes the
    // whole pipeline. Freezing everything, rather than just the output,
    // guarantees that no beat is lost or duplicated.
    logic stall;

    // Operands and lane enables as they arrive at each PE (after skew)
    logic [DW-1:0]   pe_a    [ODR];
    logic [DW-1:0]   pe_b    [ODR];
    logic            pe_en   [ODR];
    logic [ACCW-1:0] pe_prod [ODR];

    // Lane enables for the beat currently presented at the input
    logic [ODR-1:0]  lane_en;

    // PE chain state
    logic [ACCW-1:0] psum_q [ODR];
    logic [ACCW-1:0] psum_d [ODR];
    logic [ODR-1:0]  vld_q, vld_d;
    logic [ODR-1:0]  lst_q, lst_d;

    // Accumulator and output register
    logic [ACCW-1:0] acc_q, acc_d;
    logic [ACCW-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [ACCW-1:0] fin_sum;

    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Lane enables are decided at the input, with the beat's own ker_len.
    // They then travel with the skewed operands. That lets ker_len change
    // on every beat without affecting beats already in flight. Because the
    // compare uses the full integer value, a ker_len above ODR enables
    // every lane.
    always_comb begin
        lane_en = '0;
        for (int k = 0; k < ODR; k++) begin
            lane_en[k] = (k < int'(ker_len));
        end
    end

    // Lane 0 has no skew; it feeds PE 0 straight from the input port.
    assign pe_a[0]  = in_a[DW-1:0];
    assign pe_b[0]  = in_b[DW-1:0];
    assign pe_en[0] = lane_en[0];

    // Lanes 1..ODR-1 each get a private k-deep shift register for A, B and
    // the lane enable. The register holds during a stall, like the rest of
    // the pipe.
    for (genvar k = 1; k < ODR; k++) begin : g_lane
        logic [DW-1:0] skew_a_q [k];
        logic [DW-1:0] skew_a_d [k];
        logic [DW-1:0] skew_b_q [k];
        logic [DW-1:0] skew_b_d [k];
        logic          skew_en_q [k];
        logic          skew_en_d [k];

        // Next state of this lane's skew chain
        always_comb begin
            skew_a_d  = skew_a_q;
            skew_b_d  = skew_b_q;
            skew_en_d = skew_en_q;
            if (!stall) begin
                skew_a_d[0]  = in_a[k*DW +: DW];
                skew_b_d[0]  = in_b[k*DW +: DW];
                skew_en_d[0] = lane_en[k];
                for (int j = 1; j < k; j++) begin
                    skew_a_d[j]  = skew_a_q[j-1];
                    skew_b_d[j]  = skew_b_q[j-1];
                    skew_en_d[j] = skew_en_q[j-1];
                end
            end
        end

        // Skew chain registers, cleared so that no stale operand can leak
        // into a result after reset
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int j = 0; j < k; j++) begin
                    skew_a_q[j]  <= '0;
                    skew_b_q[j]  <= '0;
                    skew_en_q[j] <= 1'b0;
                end
            end else begin
                skew_a_q  <= skew_a_d;
                skew_b_q  <= skew_b_d;
                skew_en_q <= skew_en_d;
            end
        end

        assign pe_a[k]  = skew_a_q[k-1];
        assign pe_b[k]  = skew_b_q[k-1];
        assign pe_en[k] = skew_en_q[k-1];
    end

    // Masking is applied to the product, not to the operands. A disabled
    // lane contributes exactly zero, whatever its operands are.
    always_comb begin
        for (int k = 0; k < ODR; k++) begin
            pe_prod[k] = pe_en[k]
                       ? ACCW'({{DW{1'b0}}, pe_a[k]} * {{DW{1'b0}}, pe_b[k]})
                       : '0;
        end
    end

    // PE chain: PE k adds its product to the sum that PE k-1 produced on
    // the previous edge. The valid and last bits shift one stage per edge,
    // so they stay aligned with their partial sum. Bubbles (in_valid=0)
    // enter as invalid stages, so the accumulator ignores them.
    always_comb begin
        psum_d = psum_q;
        vld_d  = vld_q;
        lst_d  = lst_q;
        if (!stall) begin
            psum_d[0] = pe_prod[0];
            vld_d[0]  = in_valid;
            lst_d[0]  = in_last;
            for (int k = 1; k < ODR; k++) begin
                psum_d[k] = psum_q[k-1] + pe_prod[k];
                vld_d[k]  = vld_q[k-1];
                lst_d[k]  = lst_q[k-1];
            end
        end
    end

    // PE chain registers. Clearing the valid bits on reset discards every
    // beat that was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < ODR; k++) begin
                psum_q[k] <= '0;
            end
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            psum_q <= psum_d;
            vld_q  <= vld_d;
            lst_q  <= lst_d;
        end
    end

    // Beat total folded into the running kernel sum; wraps modulo 2^ACCW
    assign fin_sum = acc_q + psum_q[ODR-1];

    // Accumulator and output register. When the pipe is not stalled, the
    // current result has either been consumed or was never present. So
    // out_valid falls, unless a closing beat loads a new result on the same
    // edge. In that case the new value replaces the old one, and out_valid
    // stays high.
    always_comb begin
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (!stall) begin
            out_valid_d = 1'b0;
            if (vld_q[ODR-1]) begin
                if (lst_q[ODR-1]) begin
                    out_data_d  = fin_sum;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                end else begin
                    acc_d = fin_sum;
                end
            end
        end
    end

    // Accumulator and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_iiitb_sysarr_stream.sv
// ---------------------------------------------------------------------------
// tb_iiitb_sysarr_stream
//
// Testbench for iiitb_sysarr_stream (ODR=4, DW=8, ACCW=18). A monitor
// watches handshakes. For each accepted beat, it computes the expected
// result directly from the arithmetic definition: a masked dot product per
// beat, summed modulo 2^ACCW until in_last. Completed results are compared
// against what the DUT hands out.
// ---------------------------------------------------------------------------
module tb_iiitb_sysarr_stream;

    localparam int DW   = 8;
    localparam int ODR  = 4;
    localparam int KLW  = 3;
    localparam int ACCW = 18;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [ODR*DW-1:0] in_a;
    logic [ODR*DW-1:0] in_b;
    logic [KLW-1:0]    ker_len;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACCW-1:0]   out_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state and scoreboard queues
    longint acc_m = 0;
    longint exp_q[$];
    longint exp_edge_q[$];
    longint obs_q[$];
    longint obs_edge_q[$];

    iiitb_sysarr_stream #(
        .DW  (DW),
        .ODR (ODR),
        .KLW (KLW),
        .ACCW(ACCW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .ker_len  (ker_len),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change only 1ns after a rising edge, so what is seen at the
    // falling edge is exactly what the next rising edge will sample.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_m = 0;
            exp_q.delete();
            exp_edge_q.delete();
        end else begin
            if (in_valid && in_ready) begin
                longint dot;
                int     kl;
                dot = 0;
                kl  = (int'(ker_len) > ODR) ? ODR : int'(ker_len);
                for (int k = 0; k < kl; k++) begin
                    dot += longint'(in_a[k*DW +: DW]) * longint'(in_b[k*DW +: DW]);
                end
                acc_m = (acc_m + dot) % (longint'(1) << ACCW);
                if (in_last) begin
                    exp_q.push_back(acc_m);
                    exp_edge_q.push_back(longint'(cyc) + 1 + ODR + 1);
                    acc_m = 0;
                end
            end
            if (out_valid && out_ready) begin
                obs_q.push_back(longint'(out_data));
                obs_edge_q.push_back(longint'(cyc) + 1);
            end
        end
    end

    function automatic logic [ODR*DW-1:0] rand_vec();
        logic [ODR*DW-1:0] v;
        v = '0;
        for (int k = 0; k < ODR; k++) v[k*DW +: DW] = DW'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        exp_edge_q.delete();
        obs_q.delete();
        obs_edge_q.delete();
    endtask

    // Offers one beat and holds it until it is accepted (bounded wait)
    task automatic send_beat(input logic [ODR*DW-1:0] a, input logic [ODR*DW-1:0] b,
                             input logic [KLW-1:0] kl, input logic last);
        bit done = 1'b0;
        in_a     = a;
        in_b     = b;
        ker_len  = kl;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("[TB] FAIL send_timeout: accepted=%0d required=1", done);
        end
    endtask

    task automatic wait_results(input int n, input string tag);
        int waited = 0;
        while (obs_q.size() < n && waited < 300) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_checks++;
        if (obs_q.size() < n) begin
            n_fail++;
            $display("[TB] FAIL %s_timeout: got %0d results, required %0d", tag, obs_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        ker_len   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %0b required 0", out_valid); end
        if (out_data !== '0) begin n_fail++; $display("[TB] FAIL reset_out_data: got %0d required 0", out_data); end
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %0b required 1", in_ready); end
        idle(2);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_out_valid: got %0b required 0", out_valid); end
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_in_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_single_beat();
        logic [KLW-1:0] kls [4] = '{3'd4, 3'd3, 3'd0, 3'd7};
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            clear_sb();
            send_beat({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, kls[t], 1'b1);
            wait_results(1, "single");
            idle(2);
            n_checks++;
            if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
                n_fail++;
                $display("[TB] FAIL single_count: got %0d results, required 1 (model %0d)", obs_q.size(), exp_q.size());
            end else begin
                n_checks += 2;
                if (obs_q[0] !== exp_q[0]) begin
                    n_fail++;
                    $display("[TB] FAIL single_data kl=%0d: got %0d required %0d", kls[t], obs_q[0], exp_q[0]);
                end
                if (obs_edge_q[0] !== exp_edge_q[0]) begin
                    n_fail++;
                    $display("[TB] FAIL single_latency kl=%0d: handshake edge %0d required %0d", kls[t], obs_edge_q[0], exp_edge_q[0]);
                end
            end
        end
    endtask

    task automatic test_multi_beat();
        clear_sb();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_beat(32'h01010101, 32'h02020202, 3'd3, i == 2);
        wait_results(1, "multi");
        idle(6);
        n_checks++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1) begin
            n_fail++;
            $display("[TB] FAIL multi_count: got %0d results, required 1 (model %0d)", obs_q.size(), exp_q.size());
        end else begin
            n_checks++;
            if (obs_q[0] !== exp_q[0]) begin
                n_fail++;
                $display("[TB] FAIL multi_data: got %0d required %0d", obs_q[0], exp_q[0]);
            end
        end
        // A following single-lane kernel proves the accumulator restarted from zero
        clear_sb();
        send_beat(32'h01010101, 32'h02020202, 3'd1, 1'b1);
        wait_results(1, "multi_after");
        n_checks++;
        if (obs_q.size() < 1 || exp_q.size() < 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("[TB] FAIL multi_acc_cleared: got %0d required %0d",
                     (obs_q.size() > 0) ? obs_q[0] : -1, (exp_q.size() > 0) ? exp_q[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_beat(rand_vec(), rand_vec(), KLW'($urandom_range(0, 7)), 1'b1);
        wait_results(8, "stream");
        idle(2);
        n_checks++;
        if (obs_q.size() !== 8 || exp_q.size() !== 8) begin
            n_fail++;
            $display("[TB] FAIL stream_count: got %0d results, required 8 (model %0d)", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks += 2;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("[TB] FAIL stream_data[%0d]: got %0d required %0d", i, obs_q[i], exp_q[i]);
                end
                if (obs_edge_q[i] !== exp_edge_q[i]) begin
                    n_fail++;
                    $display("[TB] FAIL stream_edge[%0d]: got %0d required %0d", i, obs_edge_q[i], exp_edge_q[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        clear_sb();
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_beat(rand_vec(), rand_vec(), 3'd4, 1'b1);
            end
            begin
                int w = 0;
                while (!out_valid && w < 50) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL bp_first_valid: got %0b required 1", out_valid);
                end
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    n_checks += 3;
                    if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready c=%0d: got %0b required 0", c, in_ready); end
                    if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_out_valid c=%0d: got %0b required 1", c, out_valid); end
                    if (exp_q.size() == 0 || longint'(out_data) !== exp_q[0]) begin
                        n_fail++;
                        $display("[TB] FAIL bp_out_data c=%0d: got %0d required %0d", c, out_data,
                                 (exp_q.size() > 0) ? exp_q[0] : -1);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_results(6, "bp");
        idle(3);
        n_checks++;
        if (obs_q.size() !== 6 || exp_q.size() !== 6) begin
            n_fail++;
            $display("[TB] FAIL bp_count: got %0d results, required 6 (model %0d)", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("[TB] FAIL bp_data[%0d]: got %0d required %0d", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        clear_sb();
        out_ready = 1'b1;
        send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 1'b0);
        send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd4, 1'b1);
        wait_results(1, "ovf");
        n_checks++;
        if (obs_q.size() < 1 || exp_q.size() < 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("[TB] FAIL ovf_data: got %0d required %0d",
                     (obs_q.size() > 0) ? obs_q[0] : -1, (exp_q.size() > 0) ? exp_q[0] : -1);
        end
    endtask

    task automatic test_reset_midstream();
        clear_sb();
        out_ready = 1'b0;
        send_beat(rand_vec(), rand_vec(), 3'd4, 1'b1);
        for (int i = 0; i < 3; i++) send_beat(rand_vec(), rand_vec(), 3'd4, 1'b0);
        idle(2);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_pre_valid: got %0b required 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_valid: got %0b required 0", out_valid); end
        if (out_data !== '0) begin n_fail++; $display("[TB] FAIL mid_reset_data: got %0d required 0", out_data); end
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_reset_ready: got %0b required 1", in_ready); end
        idle(1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        clear_sb();
        send_beat(rand_vec(), rand_vec(), 3'd4, 1'b1);
        wait_results(1, "mid");
        idle(6);
        n_checks++;
        if (obs_q.size() !== 1 || exp_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("[TB] FAIL mid_post_data: got %0d results first %0d, required 1 result %0d", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : -1, (exp_q.size() > 0) ? exp_q[0] : -1);
        end
    endtask

    task automatic test_random();
        bit done = 1'b0;
        int nb   = 120;
        int n_exp;
        clear_sb();
        fork
            begin
                for (int i = 0; i < nb; i++) begin
                    int gap;
                    gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
                    idle(gap);
                    send_beat(rand_vec(), rand_vec(), KLW'($urandom_range(0, 7)),
                              (i == nb - 1) ? 1'b1 : ($urandom_range(0, 2) == 0));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        n_exp = exp_q.size();
        wait_results(n_exp, "rand");
        idle(6);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL rand_count: got %0d results, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL rand_data[%0d]: got %0d required %0d", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        $display("[TB] starting iiitb_sysarr_stream bench");
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
